// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: column strobe, 2-flop row sync, frame-based debounce, valid/ack output.
// Optional KEYPAD_HEX_MAP_EN remaps raw col*4+row codes to the Pmod KYPD legend.
module keypad_scan #(
    parameter int SCAN_DIV = 1024,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2
    } state_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Frame population saturates at 2, which stands for "multi".
    function automatic logic [1:0] sat_add(input logic [1:0] acc, input logic [2:0] n);
        logic [2:0] s;
        s = {1'b0, acc} + n;
        sat_add = (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] v);
        low_row = 2'd3;
        if (v[0])      low_row = 2'd0;
        else if (v[1]) low_row = 2'd1;
        else if (v[2]) low_row = 2'd2;
    endfunction

    function automatic logic [3:0] map_code(input logic [3:0] raw);
`ifdef KEYPAD_HEX_MAP_EN
        case (raw)
            4'd0:  map_code = 4'h1;  4'd1:  map_code = 4'h4;
            4'd2:  map_code = 4'h7;  4'd3:  map_code = 4'h0;
            4'd4:  map_code = 4'h2;  4'd5:  map_code = 4'h5;
            4'd6:  map_code = 4'h8;  4'd7:  map_code = 4'hF;
            4'd8:  map_code = 4'h3;  4'd9:  map_code = 4'h6;
            4'd10: map_code = 4'h9;  4'd11: map_code = 4'hE;
            4'd12: map_code = 4'hA;  4'd13: map_code = 4'hB;
            4'd14: map_code = 4'hC;  default: map_code = 4'hD;
        endcase
`else
        map_code = raw;
`endif
    endfunction

    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    logic [3:0]       row_s1_q, row_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       frm_cnt_q, frm_cnt_d;
    logic [3:0]       frm_code_q, frm_code_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic       sample, frame_end, emit;
    logic [3:0] pressed;
    logic [2:0] ncol;
    logic [1:0] frame_cnt;
    logic [3:0] frame_code;

    assign sample     = (div_q == DIV_LAST);
    assign frame_end  = sample && (col_q == 2'd3);
    assign pressed    = ~row_s2_q;
    assign ncol       = popcnt4(pressed);
    assign frame_cnt  = sat_add(frm_cnt_q, ncol);
    assign frame_code = (ncol == 3'd1) ? {col_q, low_row(pressed)} : frm_code_q;

    // Scan timing and per-frame accumulation
    always_comb begin
        div_d      = div_q + 1'b1;
        col_d      = col_q;
        frm_cnt_d  = frm_cnt_q;
        frm_code_d = frm_code_q;
        if (sample) begin
            div_d = '0;
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) begin
                frm_cnt_d  = '0;
                frm_code_d = '0;
            end else begin
                frm_cnt_d  = frame_cnt;
                frm_code_d = frame_code;
            end
        end
    end

    // Debounce FSM (frame-end only) and consumer handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        emit    = 1'b0;
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_cnt == 2'd1) begin
                        cand_d = frame_code;
                        if (DEBOUNCE == 1) begin
                            state_d = S_PRESSED;
                            cnt_d   = '0;
                            emit    = 1'b1;
                        end else begin
                            state_d = S_DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_cnt == 2'd1 && frame_code == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_PRESSED;
                            cnt_d   = '0;
                            emit    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_PRESSED: begin
                    if (frame_cnt != 2'd0) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (emit) begin
            if (!valid_q || key_ack) begin
                code_d  = map_code(cand_d);
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (key_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            div_q      <= '0;
            col_q      <= '0;
            frm_cnt_q  <= '0;
            frm_code_q <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            row_s1_q   <= row_n;
            row_s2_q   <= row_s1_q;
            div_q      <= div_d;
            col_q      <= col_d;
            frm_cnt_q  <= frm_cnt_d;
            frm_code_q <= frm_code_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = (state_q == S_PRESSED);
    assign overrun   = ovr_q;

endmodule
